// File: rtl/color_sequencer.sv
// Purpose : NCH independent colour channels, each either holding a manually set colour or
//           auto-advancing through colour codes 1..2^CW-1 after a programmable dwell time.
// Latency : a command shows on color_out 2 rising edges after it is offered (transfer edge + APPLY edge).
// Backpressure: valid/ready. cmd_ready drops for the APPLY cycle after every transfer, so at most
//           one command is taken every 2 cycles.
// Ports   : clk, rst (async, active low); cmd_valid/cmd_ready handshake carrying cmd_ch, cmd_mode
//           (0 manual, 1 cycle), cmd_color (0 = keep), cmd_dwell (cycles per step minus one);
//           color_out (channel k at [k*CW +: CW]), cyc_mode (per-channel cycle flag).
// Option  : define COLOR_SEQ_CHG_FLAG_EN to add color_chg, a per-channel one-cycle pulse that is
//           high in the cycle color_out first shows a new value for that channel.
module color_sequencer #(
   parameter  int NCH = 4,
   parameter  int CW  = 2,
   parameter  int DW  = 8,
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CHW-1:0]    cmd_ch,
   input  logic              cmd_mode,
   input  logic [CW-1:0]     cmd_color,
   input  logic [DW-1:0]     cmd_dwell,
   output logic [NCH*CW-1:0] color_out,
   output logic [NCH-1:0]    cyc_mode
`ifdef COLOR_SEQ_CHG_FLAG_EN
   ,
   output logic [NCH-1:0]    color_chg
`endif
);

   localparam logic [CW-1:0] CMAX = '1;

   typedef enum logic {S_IDLE = 1'b0, S_APPLY = 1'b1} state_t;

   state_t         state;
   state_t         state_nxt;
   logic           apply;

   logic [CHW-1:0] cap_ch;
   logic           cap_mode;
   logic [CW-1:0]  cap_color;
   logic [DW-1:0]  cap_dwell;

   // Handshake FSM: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Handshake FSM: next state. APPLY always lasts exactly one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (cmd_valid) state_nxt = S_APPLY;
         S_APPLY: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Handshake FSM: outputs
   always_comb begin
      cmd_ready = (state == S_IDLE);
      apply     = (state == S_APPLY);
   end

   // Command fields are sampled only on the transfer edge; inputs are ignored while busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_ch    <= '0;
         cap_mode  <= 1'b0;
         cap_color <= '0;
         cap_dwell <= '0;
      end else if (cmd_valid && cmd_ready) begin
         cap_ch    <= cmd_ch;
         cap_mode  <= cmd_mode;
         cap_color <= cmd_color;
         cap_dwell <= cmd_dwell;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [CW-1:0] color_q, color_d, color_adv;
      logic          mode_q, mode_d;
      logic [DW-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
      logic          hit;

      // An out-of-range captured index matches no channel, so such a command is a no-op.
      assign hit       = apply && (cap_ch == CHW'(k));
      // Wrap from the top code back to 1 so that NP (0) is never produced while cycling.
      assign color_adv = (color_q == CMAX) ? CW'(1) : color_q + CW'(1);

      always_comb begin
         color_d = color_q;
         mode_d  = mode_q;
         cnt_d   = cnt_q;
         dwell_d = dwell_q;
         // A command write takes priority over a dwell expiry in the same cycle.
         if (hit) begin
            mode_d = cap_mode;
            cnt_d  = '0;
            if (cap_mode) begin
               dwell_d = cap_dwell;
               if (cap_color != '0)     color_d = cap_color;
               else if (color_q == '0)  color_d = CW'(1);
            end else if (cap_color != '0) begin
               color_d = cap_color;
            end
         end else if (mode_q) begin
            if (cnt_q == dwell_q) begin
               cnt_d   = '0;
               color_d = color_adv;
            end else begin
               cnt_d   = cnt_q + DW'(1);
            end
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            color_q <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
         end else begin
            color_q <= color_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
         end
      end

      assign color_out[k*CW +: CW] = color_q;
      assign cyc_mode[k]           = mode_q;

`ifdef COLOR_SEQ_CHG_FLAG_EN
      // Registered alongside color_q, so the pulse lines up with the new colour value.
      logic chg_q;
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) chg_q <= 1'b0;
         else      chg_q <= (color_d != color_q);
      end
      assign color_chg[k] = chg_q;
`else
      // No change-flag state in this build.
`endif
   end

endmodule

// File: tb/tb_color_sequencer.sv
module tb_color_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_mode = 1'b0;
   logic [1:0] cmd_ch = 2'd0;
   logic [1:0] cmd_color = 2'd0;
   logic [7:0] cmd_dwell = 8'd0;

   logic       cmd_ready, ready3;
   logic [7:0] color_out;
   logic [3:0] cyc_mode;
   logic [5:0] col3;
   logic [2:0] mode3;
`ifdef COLOR_SEQ_CHG_FLAG_EN
   logic [3:0] color_chg;
   logic [2:0] chg3;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   color_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ch(cmd_ch), .cmd_mode(cmd_mode), .cmd_color(cmd_color), .cmd_dwell(cmd_dwell),
      .color_out(color_out), .cyc_mode(cyc_mode)
`ifdef COLOR_SEQ_CHG_FLAG_EN
      , .color_chg(color_chg)
`endif
   );

   // A 2-bit channel index cannot leave the range of a 4-channel block, so the
   // out-of-range command case is exercised on a 3-channel copy sharing the inputs.
   color_sequencer #(.NCH(3)) dut3 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready3),
      .cmd_ch(cmd_ch), .cmd_mode(cmd_mode), .cmd_color(cmd_color), .cmd_dwell(cmd_dwell),
      .color_out(col3), .cyc_mode(mode3)
`ifdef COLOR_SEQ_CHG_FLAG_EN
      , .color_chg(chg3)
`endif
   );

   typedef struct {
      logic [1:0] ch;
      logic       mode;
      logic [1:0] color;
      logic [7:0] dwell;
      logic [7:0] exp_col;
      logic [3:0] exp_mode;
   } vec_t;

   vec_t vt[9];

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic set_cmd(input logic [1:0] ch, input logic m, input logic [1:0] c, input logic [7:0] d);
      cmd_ch    = ch;
      cmd_mode  = m;
      cmd_color = c;
      cmd_dwell = d;
   endtask

   task automatic check_zero(input string name);
      check({name, "_col"},   32'(color_out), 32'h0);
      check({name, "_mode"},  32'(cyc_mode),  32'h0);
      check({name, "_ready"}, 32'(cmd_ready), 32'h1);
      check({name, "_col3"},  32'(col3),      32'h0);
      check({name, "_mode3"}, 32'(mode3),     32'h0);
`ifdef COLOR_SEQ_CHG_FLAG_EN
      check({name, "_chg"},   32'(color_chg), 32'h0);
      check({name, "_chg3"},  32'(chg3),      32'h0);
`endif
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      check_zero("rst_async");
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   function automatic logic [3:0] chg_of(input logic [7:0] a, input logic [7:0] b);
      logic [3:0] r;
      for (int k = 0; k < 4; k++) r[k] = (a[2*k +: 2] != b[2*k +: 2]);
      return r;
   endfunction

   // ch0 cycling with dwell 2 from colour 1: three cycles per colour, 1->2->3->1.
   function automatic logic [1:0] ch0_model(input int n);
      return 2'(1 + ((n / 3) % 3));
   endfunction

   initial begin
      int          seq032[12];
      int          chg032[12];
      int          exp033[7];
      int          base;
      int          idx;
      logic        was;
      logic [7:0]  prev;
      logic [1:0]  b2b_ch[4];
      logic [1:0]  b2b_col[4];

      vt[0] = '{2'd1, 1'b0, 2'd2, 8'd0,   8'h08, 4'h0};
      vt[1] = '{2'd1, 1'b0, 2'd0, 8'd0,   8'h08, 4'h0};
      vt[2] = '{2'd3, 1'b0, 2'd3, 8'd0,   8'hC8, 4'h0};
      vt[3] = '{2'd0, 1'b1, 2'd0, 8'd255, 8'hC9, 4'h1};
      vt[4] = '{2'd2, 1'b1, 2'd2, 8'd255, 8'hE9, 4'h5};
      vt[5] = '{2'd2, 1'b1, 2'd0, 8'd255, 8'hE9, 4'h5};
      vt[6] = '{2'd0, 1'b0, 2'd0, 8'd0,   8'hE9, 4'h4};
      vt[7] = '{2'd2, 1'b0, 2'd1, 8'd0,   8'hD9, 4'h0};
      vt[8] = '{2'd3, 1'b0, 2'd0, 8'd0,   8'hD9, 4'h0};

      seq032 = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 1, 1, 1};
      chg032 = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
      exp033 = '{1, 2, 3, 1, 3, 3, 3};
      b2b_ch  = '{2'd0, 2'd1, 2'd2, 2'd3};
      b2b_col = '{2'd1, 2'd2, 2'd3, 2'd1};

      // Power-on reset, then idle with outputs at their reset values.
      #2 rst = 1'b0;
      #1 check_zero("por");
      @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle_col",   32'(color_out), 32'h0);
         check("idle_mode",  32'(cyc_mode),  32'h0);
         check("idle_ready", 32'(cmd_ready), 32'h1);
      end

      // Directed command table: one command every 2 cycles.
      prev = 8'h00;
      for (int i = 0; i < 9; i++) begin
         set_cmd(vt[i].ch, vt[i].mode, vt[i].color, vt[i].dwell);
         cmd_valid = 1'b1;
         step();
         cmd_valid = 1'b0;
         check("tbl_busy",  32'(cmd_ready), 32'h0);
         step();
         check("tbl_col",   32'(color_out), 32'(vt[i].exp_col));
         check("tbl_mode",  32'(cyc_mode),  32'(vt[i].exp_mode));
         check("tbl_ready", 32'(cmd_ready), 32'h1);
         check("tbl_col3",  32'(col3),      32'(vt[i].exp_col[5:0]));
         check("tbl_mode3", 32'(mode3),     32'(vt[i].exp_mode[2:0]));
`ifdef COLOR_SEQ_CHG_FLAG_EN
         check("tbl_chg",   32'(color_chg), 32'(chg_of(prev, vt[i].exp_col)));
`endif
         prev = vt[i].exp_col;
      end

      // Cycling with dwell 2: three cycles per colour and wrap from 3 to 1.
      do_reset();
      set_cmd(2'd0, 1'b1, 2'd1, 8'd2);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      step();
      base = cyc;
      for (int i = 0; i < 12; i++) begin
         check("cyc_seq", 32'(color_out[1:0]), 32'(seq032[i]));
`ifdef COLOR_SEQ_CHG_FLAG_EN
         check("cyc_chg", 32'(color_chg[0]), 32'(chg032[i]));
`endif
         step();
      end

      // Dwell 0 on ch2 from NP, then a manual write landing on an expiry cycle.
      // ch0 keeps cycling throughout and must not be disturbed.
      set_cmd(2'd2, 1'b1, 2'd0, 8'd0);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      check("d0_ch0_xfer", 32'(color_out[1:0]), 32'(ch0_model(cyc - base)));
      step();
      for (int i = 0; i < 7; i++) begin
         check("d0_ch2", 32'(color_out[5:4]), 32'(exp033[i]));
         check("d0_ch0", 32'(color_out[1:0]), 32'(ch0_model(cyc - base)));
         if (i == 2) begin
            set_cmd(2'd2, 1'b0, 2'd3, 8'd0);
            cmd_valid = 1'b1;
         end else begin
            cmd_valid = 1'b0;
         end
         step();
      end
      check("d0_mode", 32'(cyc_mode), 32'h1);

      // Back-to-back offers with valid held high; fields change while busy.
      do_reset();
      idx = 0;
      set_cmd(b2b_ch[0], 1'b0, b2b_col[0], 8'd0);
      cmd_valid = 1'b1;
      for (int e = 0; e < 8; e++) begin
         was = cmd_ready;
         step();
         check("b2b_ready", 32'(cmd_ready), 32'(!was));
         if (was) begin
            idx++;
            set_cmd(cmd_ch, 1'b1, 2'd2, 8'd5);
         end else if (idx < 4) begin
            set_cmd(b2b_ch[idx], 1'b0, b2b_col[idx], 8'd0);
         end
      end
      cmd_valid = 1'b0;
      check("b2b_count", 32'(idx),       32'd4);
      check("b2b_col",   32'(color_out), 32'h79);
      check("b2b_mode",  32'(cyc_mode),  32'h0);
      check("b2b_col3",  32'(col3),      32'h39);
      check("b2b_mode3", 32'(mode3),     32'h0);

      // Out-of-range channel: handshake completes, no channel of the 3-channel copy changes.
      set_cmd(2'd3, 1'b1, 2'd2, 8'd0);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      check("oor_busy",  32'(ready3), 32'h0);
      step();
      check("oor_ready", 32'(ready3), 32'h1);
      check("oor_col3",  32'(col3),   32'h39);
      check("oor_mode3", 32'(mode3),  32'h0);
      check("oor_main",  32'(cyc_mode), 32'h8);

      // Reset in the middle of APPLY: pending command must be lost.
      set_cmd(2'd0, 1'b0, 2'd3, 8'd0);
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      check("mid_busy", 32'(cmd_ready), 32'h0);
      #2 rst = 1'b0;
      #1 check_zero("mid_rst");
      @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_col",   32'(color_out), 32'h0);
         check("post_ready", 32'(cmd_ready), 32'h1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
